register_file: RTL

- Parametrised multi-entry register storage; the successor to the fixed 32-bit D-register.
- Holds DEPTH words of WIDTH bits, with one write port and two independent read ports.
- Options: hardwired-zero entry 0, write-to-read bypass, and combinational or registered read.
- Sits between datapath producers and consumers as the general-purpose register bank.

---
 rtl/regfile_pkg.sv | 20 ++
 rtl/regfile_read_port.sv | 72 +++++++
 rtl/register_file.sv | 79 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and address qualification for the register file
//
// Purpose: default geometry for the register bank plus the address legality
// check used for both write qualification and read range/zero masking.
// Ports: none (package).

package regfile_pkg;

  localparam int REGFILE_WIDTH = 32;
  localparam int REGFILE_DEPTH = 32;

  // An address is usable when it names a real entry and is not the
  // hardwired-zero entry.
  function automatic logic addr_legal(input int unsigned addr,
                                      input int unsigned depth,
                                      input logic        zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - one read port: range check, zero masking, bypass, optional output register
//
// Purpose: selects the read source for one port of the register file and
// optionally registers it.
// Ports:
//   clk, reset_n  clock and asynchronous active-low reset (output register only)
//   clr           synchronous clear, zeroes the output register when REG_OUT=1
//   wr_ok         the write this cycle is legal and will be committed
//   wr_addr/data  write port, used as the bypass source
//   mem           current storage contents
//   rd_addr       read address
//   rd_data       read data (latency 0 or 1 depending on REG_OUT)

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = REGFILE_WIDTH,
  parameter  int DEPTH    = REGFILE_DEPTH,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  parameter  int REG_OUT  = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              wr_ok,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [WIDTH-1:0]  mem [DEPTH],
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] rd_src;

  // Out-of-range and zero-entry reads yield 0 before bypass is considered,
  // so a discarded write can never leak through the bypass path.
  always_comb begin
    rd_src = '0;
    if (addr_legal(32'(rd_addr), DEPTH, ZERO_REG != 0)) begin
      if ((BYPASS != 0) && wr_ok && (rd_addr == wr_addr)) begin
        rd_src = wr_data;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_addr == ADDR_W'(i)) rd_src = mem[i];
        end
      end
    end
  end

  if (REG_OUT != 0) begin : g_reg
    logic [WIDTH-1:0] rd_data_q;
    logic [WIDTH-1:0] rd_data_d;

    always_comb begin
      rd_data_d = clr ? '0 : rd_src;
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_data_q <= '0;
      else          rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;
  end else begin : g_comb
    logic unused_sync;
    assign unused_sync = ^{clk, reset_n, clr};
    assign rd_data     = rd_src;
  end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - parametrised register bank, one write port and two read ports
//
// Purpose: DEPTH x WIDTH flop storage with optional hardwired-zero entry,
// write-to-read bypass and registered read.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset, zeroes all entries
//   clr      synchronous clear of all entries (wins over a write)
//   we       write enable; wr_addr / wr_data write address and data
//   ra_addr / ra_data  read port A
//   rb_addr / rb_data  read port B

module register_file
  import regfile_pkg::*;
#(
  parameter  int WIDTH    = REGFILE_WIDTH,
  parameter  int DEPTH    = REGFILE_DEPTH,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  parameter  int REG_OUT  = 0,
  localparam int ADDR_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] ra_addr,
  output logic [WIDTH-1:0]  ra_data,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [WIDTH-1:0]  rb_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_ok;

  // wr_ok also qualifies the bypass in both read ports, so a write that is
  // dropped (clear, out of range, zero entry) is invisible everywhere.
  always_comb begin
    wr_ok = we && !clr && addr_legal(32'(wr_addr), DEPTH, ZERO_REG != 0);
    mem_d = mem_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (clr) begin
        mem_d[i] = '0;
      end else if (wr_ok && (wr_addr == ADDR_W'(i))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  regfile_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG),
    .BYPASS(BYPASS), .REG_OUT(REG_OUT)
  ) u_port_a (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_ok(wr_ok),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem(mem_q),
    .rd_addr(ra_addr), .rd_data(ra_data)
  );

  regfile_read_port #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG),
    .BYPASS(BYPASS), .REG_OUT(REG_OUT)
  ) u_port_b (
    .clk(clk), .reset_n(reset_n), .clr(clr), .wr_ok(wr_ok),
    .wr_addr(wr_addr), .wr_data(wr_data), .mem(mem_q),
    .rd_addr(rb_addr), .rd_data(rb_data)
  );

endmodule
